// File: rtl/sram_responder_pkg.sv
// Shared definitions for sram_responder: FSM state encodings, default base address, lane geometry.
package sram_responder_pkg;
  typedef enum logic {
    SRAM_ST_CLEAR = 1'b0,
    SRAM_ST_READY = 1'b1
  } sram_st_e;

  localparam logic [31:0] SRAM_DEFAULT_BASE = 32'h1c00_0000;
  localparam int          SRAM_LANE_W       = 8;
  localparam int          SRAM_NUM_LANES    = 4;
endpackage

// File: rtl/sram_byte_lane.sv
// One byte lane of the SRAM: 8-bit x 2**AW array, registered read-first output (1-cycle latency).
// No backpressure; the output register only updates on ld_i/zero_i and otherwise holds.
module sram_byte_lane
  import sram_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic                   ld_i,
  input  logic                   zero_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [SRAM_LANE_W-1:0] wdata_i,
  output logic [SRAM_LANE_W-1:0] rdata_o
);

  logic [SRAM_LANE_W-1:0] mem_q [2**AW];
  logic [SRAM_LANE_W-1:0] rdata_q;
  logic [SRAM_LANE_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Output samples the pre-write word, so a write cycle returns old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (zero_i)    rdata_d = '0;
    else if (ld_i) rdata_d = mem_q[addr_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Single-port SRAM responder: byte-lane writes, 1-cycle read-first reads, post-reset clear sweep, sticky range error.
// No stall path; requests are ignored while init_busy. Optional access counters under SRAM_STATS_EN.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int          AW           = 10,
  parameter logic [31:0] BASE_ADDR    = SRAM_DEFAULT_BASE,
  parameter int          CLEAR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        init_busy,
  output logic        addr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam sram_st_e      ST_RESET = (CLEAR_ON_RST != 0) ? SRAM_ST_CLEAR : SRAM_ST_READY;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  sram_st_e                state_q, state_d;
  logic [AW-1:0]           clr_ptr_q, clr_ptr_d;
  logic                    addr_err_q, addr_err_d;
  logic [31:0]             offset;
  logic [AW-1:0]           idx;
  logic                    in_range;
  logic                    unused_lsb;
  logic [SRAM_NUM_LANES-1:0] lane_we;
  logic [AW-1:0]           lane_addr;
  logic [31:0]             lane_wdata;
  logic                    rd_ld;
  logic                    rd_zero;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign offset     = sram_addr - BASE_ADDR;
  assign idx        = offset[AW+1:2];
  assign in_range   = (offset[31:AW+2] == '0);
  assign unused_lsb = ^offset[1:0];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    addr_err_d = addr_err_q;
    lane_we    = '0;
    lane_addr  = idx;
    lane_wdata = sram_wdata;
    rd_ld      = 1'b0;
    rd_zero    = 1'b0;
    unique case (state_q)
      SRAM_ST_CLEAR: begin
        lane_we    = '1;
        lane_addr  = clr_ptr_q;
        lane_wdata = '0;
        rd_zero    = 1'b1;
        clr_ptr_d  = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == '1) state_d = SRAM_ST_READY;
      end
      default: begin
        if (sram_en) begin
          if (in_range) begin
            rd_ld   = 1'b1;
            lane_we = sram_we;
          end else begin
            rd_zero    = 1'b1;
            addr_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_RESET;
      clr_ptr_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      addr_err_q <= addr_err_d;
    end
  end

  for (genvar l = 0; l < SRAM_NUM_LANES; l++) begin : g_lane
    sram_byte_lane #(.AW(AW)) u_lane (
      .clk     (clk),
      .rst_n   (resetn),
      .we_i    (lane_we[l]),
      .ld_i    (rd_ld),
      .zero_i  (rd_zero),
      .addr_i  (lane_addr),
      .wdata_i (lane_wdata[SRAM_LANE_W*l +: SRAM_LANE_W]),
      .rdata_o (sram_rdata[SRAM_LANE_W*l +: SRAM_LANE_W])
    );
  end

  assign init_busy = (state_q == SRAM_ST_CLEAR);
  assign addr_err  = addr_err_q;

`ifdef SRAM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        rd_acc, wr_acc;

  assign rd_acc   = (state_q == SRAM_ST_READY) & sram_en & in_range & (sram_we == 4'h0);
  assign wr_acc   = (state_q == SRAM_ST_READY) & sram_en & in_range & (sram_we != 4'h0);
  assign rd_cnt_d = rd_acc ? rd_cnt_q + 32'd1 : rd_cnt_q;
  assign wr_cnt_d = wr_acc ? wr_cnt_q + 32'd1 : wr_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (AW=4, CLEAR_ON_RST=1): directed table, hand sequences, random vs model.
module tb_sram_responder;

  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          DEPTH = 16;
`ifdef SRAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_busy;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  sram_responder #(.AW(4), .BASE_ADDR(BASE), .CLEAR_ON_RST(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .init_busy  (init_busy),
    .addr_err   (addr_err),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus expected output register state.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  int unsigned m_rd, m_wr;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_rdata = 32'h0;
    m_err   = 1'b0;
    m_rd    = 0;
    m_wr    = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wd);
    logic [31:0] off;
    int          w;
    if (!en) return;
    off = addr - BASE;
    if (off >= 32'(4 * DEPTH)) begin
      m_rdata = 32'h0;
      m_err   = 1'b1;
    end else begin
      w       = int'(off / 4);
      m_rdata = m_mem[w];
      if (we == 4'h0) m_rd++;
      else begin
        m_wr++;
        for (int l = 0; l < 4; l++)
          if (we[l]) m_mem[w][8*l +: 8] = wd[8*l +: 8];
      end
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
    model_step(en, we, addr, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic random_inputs();
    sram_en    = ($urandom_range(0, 3) != 0);
    sram_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
    sram_addr  = ($urandom_range(0, 9) < 7) ? BASE + 32'($urandom_range(0, 63)) : $urandom;
    sram_wdata = $urandom;
  endtask

  // Counts edges from reset release; busy must hold for exactly DEPTH edges with requests ignored.
  task automatic check_sweep();
    for (int k = 1; k <= DEPTH; k++) begin
      random_inputs();
      @(posedge clk);
      #1;
      chk("sweep_busy", {31'b0, init_busy}, {31'b0, (k < DEPTH)});
      chk("sweep_rdata", sram_rdata, 32'h0);
      chk("sweep_err", {31'b0, addr_err}, 32'h0);
    end
    sram_en = 1'b0;
    model_reset();
    chk("sweep_rd_cnt", rd_cnt, 32'h0);
    chk("sweep_wr_cnt", wr_cnt, 32'h0);
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    sram_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, init_busy}, 32'h1);
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_err", {31'b0, addr_err}, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_wr_cnt", wr_cnt, 32'h0);
    resetn = 1'b1;
    check_sweep();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'hF, BASE + 32'h08,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 4'h2, BASE + 32'h08,  32'h0000_5500, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, BASE + 32'h08,  32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[3]  = '{1'b0, 4'hF, BASE + 32'h08,  32'hFFFF_FFFF, 32'hDEAD_55EF, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, BASE + 32'h08,  32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[5]  = '{1'b1, 4'hF, BASE + 32'h04,  32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 4'hF, BASE + 32'h04,  32'hAAAA_AAAA, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, BASE + 32'h04,  32'h0,         32'hAAAA_AAAA, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, BASE + 32'h40,  32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, BASE + 32'h08,  32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 4'h0, BASE + 32'h08,  32'h0,         32'hDEAD_55EF, 1'b1};
    vecs[11] = '{1'b1, 4'hF, BASE - 32'h04,  32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 4'h5, BASE + 32'h3c,  32'h0BAD_F00D, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, 4'h0, BASE + 32'h3f,  32'h0,         32'h00AD_000D, 1'b1};
    vecs[14] = '{1'b1, 4'hF, BASE + 32'h108, 32'h2222_2222, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 4'h0, BASE + 32'h08,  32'h0,         32'hDEAD_55EF, 1'b1};

    resetn     = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    model_reset();
    #12;

    // Reset values, then a full 16-cycle clear sweep.
    do_reset();

    // Every word reads zero after the sweep.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      chk("clear_read", sram_rdata, 32'h0);
    end

    // Directed table: lane writes, read-first, range errors, hold on idle.
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata", i), sram_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
    end
    chk("vec_rd_cnt", rd_cnt, STATS ? 32'(m_rd) : 32'h0);
    chk("vec_wr_cnt", wr_cnt, STATS ? 32'(m_wr) : 32'h0);

    // Random traffic against the model from a fresh reset.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      random_inputs();
      drive(sram_en, sram_we, sram_addr, sram_wdata);
      chk("rand_rdata", sram_rdata, m_rdata);
      chk("rand_err", {31'b0, addr_err}, {31'b0, m_err});
    end
    chk("rand_rd_cnt", rd_cnt, STATS ? 32'(m_rd) : 32'h0);
    chk("rand_wr_cnt", wr_cnt, STATS ? 32'(m_wr) : 32'h0);
    chk("rand_busy", {31'b0, init_busy}, 32'h0);

    // Reset reasserted while the sweep is at word 7 restarts the whole sweep.
    sram_en = 1'b0;
    resetn  = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk("mid_busy", {31'b0, init_busy}, 32'h1);
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, init_busy}, 32'h1);
    chk("mid_rst_rdata", sram_rdata, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      chk("mid_clear_read", sram_rdata, 32'h0);
    end

    // Counter sequence: 3 reads, 2 writes, 1 out-of-range read on top of the 16 reads above.
    drive(1'b1, 4'hF, BASE + 32'h00, 32'h0102_0304);
    drive(1'b1, 4'hF, BASE + 32'h0c, 32'hA5A5_5A5A);
    drive(1'b1, 4'h0, BASE + 32'h00, 32'h0);
    chk("cnt_seq_rdata0", sram_rdata, 32'h0102_0304);
    drive(1'b1, 4'h0, BASE + 32'h0c, 32'h0);
    chk("cnt_seq_rdata1", sram_rdata, 32'hA5A5_5A5A);
    drive(1'b1, 4'h0, BASE + 32'h04, 32'h0);
    drive(1'b1, 4'h0, BASE + 32'h80, 32'h0);
    drive(1'b0, 4'h0, BASE, 32'h0);
    chk("cnt_seq_err", {31'b0, addr_err}, 32'h1);
    chk("cnt_seq_rd_cnt", rd_cnt, STATS ? 32'd19 : 32'h0);
    chk("cnt_seq_wr_cnt", wr_cnt, STATS ? 32'd2 : 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
